// File: rtl/alu_serial_sequencer_if.sv
// Request/response bundle for alu_serial_sequencer.
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high; the initiator holds valid and its
// payload stable until that edge, and ready may depend on state but never on
// valid of the same channel.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             ovf;

  // Host side: issues requests, consumes results.
  modport master (
    output in_valid, ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  in_valid, ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, cout, ovf
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice (Ainvert, Binvert, 2-bit op,
// carry chain) is stepped LSB to MSB, one bit per clock, over a WIDTH-bit
// operand pair. Result, zero, carry-out and overflow are returned over a
// valid/ready handshake. Operands are shifted right each RUN cycle so the
// slice always reads bit 0, and results shift in from the MSB end so bit 0
// lands at position 0 after WIDTH steps.
// Optional feature macro: ALU_SEQ_OVF_EN (signed overflow flag and
// overflow-corrected SLT). Without it ovf is tied 0 and SLT uses the raw sign.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_serial_sequencer_if.slave bus,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             cout_q;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             c_out;
  logic             sel_bit;
  logic             less;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_res;

`ifdef ALU_SEQ_OVF_EN
  logic             ovf_q;
  logic             ovf_slice;
`endif

  // One ALU slice on the current bit, plus the end-of-operation result view.
  always_comb begin
    a_bit   = a_q[0] ^ ctrl_q[3];
    b_bit   = b_q[0] ^ ctrl_q[2];
    sum_bit = a_bit ^ b_bit ^ carry;
    c_out   = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    sel_bit = 1'b0;
    case (ctrl_q[1:0])
      2'b00:   sel_bit = a_bit & b_bit;
      2'b01:   sel_bit = a_bit | b_bit;
      2'b10:   sel_bit = sum_bit;
      default: sel_bit = 1'b0;
    endcase
    res_next = {sel_bit, res_q[WIDTH-1:1]};
`ifdef ALU_SEQ_OVF_EN
    // On the MSB step, carry is the carry into the MSB slice.
    ovf_slice = carry ^ c_out;
    less      = sum_bit ^ ovf_slice;
`else
    less      = sum_bit;
`endif
    final_res = (ctrl_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, less} : res_next;
  end

  // Sequencer FSM: capture in IDLE, one slice step per RUN cycle, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            ctrl_q <= bus.ctrl;
            idx    <= '0;
            carry  <= bus.ctrl[2];
            state  <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= c_out;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            res_q  <= final_res;
            zero_q <= (final_res == '0);
            cout_q <= c_out;
`ifdef ALU_SEQ_OVF_EN
            ovf_q  <= ctrl_q[1] ? ovf_slice : 1'b0;
`endif
            state  <= DONE;
          end else begin
            res_q <= res_next;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
`ifdef ALU_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif
  assign state_dbg     = state;

endmodule
